// File: rtl/bin2bcd_seq_if.sv
// Handshake and result bundle between the processor output port and bin2bcd_seq.
// The master issues start/bin_in; the slave (converter) returns busy/done/bcd/overflow.
interface bin2bcd_seq_if;
  logic        start;
  logic [31:0] bin_in;
  logic        busy;
  logic        done;
  logic [31:0] bcd;
  logic        overflow;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd,
    input  overflow
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd,
    output overflow
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative 32-bit binary to 8-digit BCD converter (double dabble, 32 cycles per value).
// Optional macro BIN2BCD_LEADING_ZERO_BLANK_EN writes leading zero digits as 4'hF.
module bin2bcd_seq (
  input  logic                sys_clock,
  input  logic                reset,
  bin2bcd_seq_if.slave        bus
);

  typedef enum logic {
    IDLE,
    CONV
  } state_t;

  state_t      state, state_next;
  logic [31:0] shift_q, shift_next;
  logic [39:0] acc_q, acc_next;
  logic [4:0]  count_q, count_next;
  logic [31:0] bcd_q, bcd_next;
  logic        overflow_q, overflow_next;
  logic        done_q, done_next;
  logic        busy_q, busy_next;
  logic [39:0] acc_shifted;

  function automatic logic [39:0] add3_digits(input logic [39:0] acc);
    logic [39:0] res;
    res = acc;
    for (int i = 0; i < 10; i++) begin
      if (acc[i*4 +: 4] >= 4'd5)
        res[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
    end
    return res;
  endfunction

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
  // Digits above the highest nonzero one become blank; the units digit always shows.
  function automatic logic [31:0] blank_leading(input logic [31:0] digits);
    logic [31:0] res;
    logic        seen_nonzero;
    res          = digits;
    seen_nonzero = 1'b0;
    for (int i = 7; i >= 1; i--) begin
      if (digits[i*4 +: 4] != 4'd0)
        seen_nonzero = 1'b1;
      if (!seen_nonzero)
        res[i*4 +: 4] = 4'hF;
    end
    return res;
  endfunction
`endif

  assign acc_shifted = {add3_digits(acc_q)[38:0], shift_q[31]};

  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_q    <= '0;
      acc_q      <= '0;
      count_q    <= '0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_next;
      shift_q    <= shift_next;
      acc_q      <= acc_next;
      count_q    <= count_next;
      bcd_q      <= bcd_next;
      overflow_q <= overflow_next;
      done_q     <= done_next;
      busy_q     <= busy_next;
    end
  end

  // Results are only written on the final shift, so bcd/overflow never show partial values.
  always_comb begin
    state_next    = state;
    shift_next    = shift_q;
    acc_next      = acc_q;
    count_next    = count_q;
    bcd_next      = bcd_q;
    overflow_next = overflow_q;
    done_next     = 1'b0;
    busy_next     = busy_q;

    unique case (state)
      IDLE: begin
        if (bus.start) begin
          shift_next = bus.bin_in;
          acc_next   = '0;
          count_next = '0;
          busy_next  = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        shift_next = {shift_q[30:0], 1'b0};
        acc_next   = acc_shifted;
        count_next = count_q + 5'd1;
        if (count_q == 5'd31) begin
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
          bcd_next = blank_leading(acc_shifted[31:0]);
`else
          bcd_next = acc_shifted[31:0];
`endif
          overflow_next = (acc_shifted[39:32] != 8'd0);
          done_next     = 1'b1;
          busy_next     = 1'b0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.bcd      = bcd_q;
  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random values against an
// arithmetic decimal model (honours BIN2BCD_LEADING_ZERO_BLANK_EN like the design).
module tb_bin2bcd_seq;

  logic sys_clock;
  logic reset;
  int   vectors;
  int   miscompares;

  bin2bcd_seq_if bus ();

  bin2bcd_seq dut (
    .sys_clock (sys_clock),
    .reset     (reset),
    .bus       (bus)
  );

  initial begin
    sys_clock = 1'b0;
    forever #5 sys_clock = ~sys_clock;
  end

  // Reference: decimal digits of value mod 10^8 by plain division, overflow in bit 32.
  function automatic logic [32:0] model(input logic [31:0] v);
    longint      m;
    longint      p;
    logic [31:0] digits;
    m      = longint'(v) % 64'd100000000;
    p      = 1;
    digits = '0;
    for (int i = 0; i < 8; i++) begin
      digits[i*4 +: 4] = 4'((m / p) % 10);
`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
      if (i > 0 && m < p)
        digits[i*4 +: 4] = 4'hF;
`endif
      p = p * 10;
    end
    return {(longint'(v) > 64'd99999999), digits};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Present a value with start for one accepting edge, then scramble bin_in.
  task automatic applyStimulus(input logic [31:0] v, input bit align_negedge);
    if (align_negedge)
      @(negedge sys_clock);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge sys_clock);
    #1;
    bus.start  = 1'b0;
    bus.bin_in = $urandom;
  endtask

  // Full conversion: checks latency, results and status; optionally fires a start mid-run.
  task automatic runCheck(input logic [31:0] v, input bit align_negedge,
                          input int inject_at, input logic [31:0] inject_val);
    logic [32:0] exp_val;
    int          lat;
    exp_val = model(v);
    applyStimulus(v, align_negedge);
    checkOutput("busy_after_accept", 64'(bus.busy), 64'd1);
    lat = -1;
    for (int i = 1; i <= 45; i++) begin
      @(posedge sys_clock);
      #1;
      bus.start = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
      if (i == inject_at) begin
        bus.start  = 1'b1;
        bus.bin_in = inject_val;
      end
    end
    checkOutput("done_latency", 64'(lat), 64'd32);
    checkOutput("bcd", 64'(bus.bcd), 64'(exp_val[31:0]));
    checkOutput("overflow", 64'(bus.overflow), 64'(exp_val[32]));
    checkOutput("busy_at_done", 64'(bus.busy), 64'd0);
  endtask

  initial begin
    int          done_count;
    logic [31:0] v;

    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.bin_in  = '0;

    repeat (3) @(posedge sys_clock);
    #1;
    checkOutput("reset_bcd", 64'(bus.bcd), 64'd0);
    checkOutput("reset_busy", 64'(bus.busy), 64'd0);
    @(negedge sys_clock);
    reset = 1'b0;

    done_count = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge sys_clock);
      #1;
      if (bus.done) done_count++;
    end
    checkOutput("idle_done_pulses", 64'(done_count), 64'd0);
    checkOutput("idle_bcd", 64'(bus.bcd), 64'd0);
    checkOutput("idle_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("idle_busy", 64'(bus.busy), 64'd0);

    runCheck(32'h00BC_614E, 1'b1, 0, '0);
    runCheck(32'hFFFF_FFFF, 1'b1, 0, '0);
    runCheck(32'd99999999, 1'b1, 0, '0);
    runCheck(32'd100000005, 1'b1, 0, '0);
    runCheck(32'd42, 1'b1, 0, '0);
    runCheck(32'd0, 1'b1, 0, '0);

    // Start while busy is ignored; a start in the done cycle is taken at the next edge.
    runCheck(32'd7, 1'b1, 10, 32'd12345);
    runCheck(32'd12345, 1'b0, 0, '0);
    @(posedge sys_clock);
    #1;
    checkOutput("done_width", 64'(bus.done), 64'd0);

    // Abort mid-conversion with reset.
    applyStimulus(32'd500, 1'b1);
    repeat (9) @(posedge sys_clock);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("abort_bcd", 64'(bus.bcd), 64'd0);
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_overflow", 64'(bus.overflow), 64'd0);
    checkOutput("abort_done", 64'(bus.done), 64'd0);
    repeat (2) @(posedge sys_clock);
    @(negedge sys_clock);
    reset = 1'b0;
    done_count = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge sys_clock);
      #1;
      if (bus.done) done_count++;
    end
    checkOutput("abort_no_done", 64'(done_count), 64'd0);
    runCheck(32'd500, 1'b1, 0, '0);

    for (int n = 0; n < 24; n++) begin
      case (n % 4)
        0:       v = $urandom;
        1:       v = $urandom_range(0, 999);
        2:       v = $urandom_range(99999990, 100000010);
        default: v = $urandom_range(0, 99999999);
      endcase
      runCheck(v, 1'b1, 0, '0);
      @(posedge sys_clock);
      #1;
      checkOutput("done_width", 64'(bus.done), 64'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
